// File: rtl/id_stage.sv
// RV32I instruction-decode stage: drives the regfile read ports, forwards operands
// from EX/MEM, detects load-use hazards and registers the decoded result into ID/EX.
module id_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [XLEN-1:0]    if_pc,
    input  logic [31:0]        if_inst,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic               ex_wr_en,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_wr_addr,
    input  logic [XLEN-1:0]    ex_wr_data,
    input  logic               mem_wr_en,
    input  logic [RADDR_W-1:0] mem_wr_addr,
    input  logic [XLEN-1:0]    mem_wr_data,
    output logic               id_valid,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_rs1_val,
    output logic [XLEN-1:0]    id_rs2_val,
    output logic [XLEN-1:0]    id_imm,
    output logic               id_use_imm,
    output logic [RADDR_W-1:0] id_rd,
    output logic               id_wr_en,
    output logic [3:0]         id_alu_op,
    output logic               id_is_load,
    output logic               id_is_store,
    output logic               id_is_branch,
    output logic               id_is_jump,
    output logic               id_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1Val;
        logic [XLEN-1:0]    rs2Val;
        logic [XLEN-1:0]    imm;
        logic               useImm;
        logic [RADDR_W-1:0] rd;
        logic               wrEn;
        logic [3:0]         aluOp;
        logic               isLoad;
        logic               isStore;
        logic               isBranch;
        logic               isJump;
        logic               illegal;
    } idex_t;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [XLEN-1:0]    immI;
    logic [XLEN-1:0]    immS;
    logic [XLEN-1:0]    immB;
    logic [XLEN-1:0]    immU;
    logic [XLEN-1:0]    immJ;
    logic [XLEN-1:0]    fwdRs1;
    logic [XLEN-1:0]    fwdRs2;
    logic               useRs1;
    logic               useRs2;
    logic               writesRd;
    logic               loadUse;
    idex_t              dec;
    idex_t              idex_d;
    idex_t              idex_q;

    assign opcode    = if_inst[6:0];
    assign funct3    = if_inst[14:12];
    assign funct7b5  = if_inst[30];
    assign rs1       = if_inst[19:15];
    assign rs2       = if_inst[24:20];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    assign immI = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
    assign immS = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign immB = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign immU = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'h000};
    assign immJ = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

    // SUB only exists in register form; SRAI/SRA share the funct7[5] select.
    function automatic alu_op_e arithOp(input logic [2:0] f3, input logic alt, input logic isReg);
        case (f3)
            3'b000:  return (isReg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        if (rs1 == '0)                              fwdRs1 = '0;
        else if (ex_wr_en && ex_wr_addr == rs1)     fwdRs1 = ex_wr_data;
        else if (mem_wr_en && mem_wr_addr == rs1)   fwdRs1 = mem_wr_data;
        else                                        fwdRs1 = rf_rdata1;
    end

    always_comb begin
        if (rs2 == '0)                              fwdRs2 = '0;
        else if (ex_wr_en && ex_wr_addr == rs2)     fwdRs2 = ex_wr_data;
        else if (mem_wr_en && mem_wr_addr == rs2)   fwdRs2 = mem_wr_data;
        else                                        fwdRs2 = rf_rdata2;
    end

    always_comb begin
        dec        = '0;
        useRs1     = 1'b0;
        useRs2     = 1'b0;
        writesRd   = 1'b0;
        dec.valid  = 1'b1;
        dec.pc     = if_pc;
        dec.rd     = if_inst[11:7];
        dec.aluOp  = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                useRs1    = 1'b1;
                useRs2    = 1'b1;
                writesRd  = 1'b1;
                dec.aluOp = arithOp(funct3, funct7b5, 1'b1);
            end
            OPC_OPIMM: begin
                useRs1     = 1'b1;
                writesRd   = 1'b1;
                dec.imm    = immI;
                dec.useImm = 1'b1;
                dec.aluOp  = arithOp(funct3, funct7b5, 1'b0);
            end
            OPC_LOAD: begin
                useRs1     = 1'b1;
                writesRd   = 1'b1;
                dec.imm    = immI;
                dec.useImm = 1'b1;
                dec.isLoad = 1'b1;
            end
            OPC_STORE: begin
                useRs1      = 1'b1;
                useRs2      = 1'b1;
                dec.imm     = immS;
                dec.useImm  = 1'b1;
                dec.isStore = 1'b1;
            end
            OPC_BRANCH: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                dec.imm      = immB;
                dec.aluOp    = ALU_SUB;
                dec.isBranch = 1'b1;
            end
            OPC_LUI: begin
                writesRd   = 1'b1;
                dec.imm    = immU;
                dec.useImm = 1'b1;
                dec.aluOp  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                writesRd   = 1'b1;
                dec.imm    = immU;
                dec.useImm = 1'b1;
            end
            OPC_JAL: begin
                writesRd   = 1'b1;
                dec.imm    = immJ;
                dec.useImm = 1'b1;
                dec.isJump = 1'b1;
            end
            OPC_JALR: begin
                useRs1     = 1'b1;
                writesRd   = 1'b1;
                dec.imm    = immI;
                dec.useImm = 1'b1;
                dec.isJump = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.wrEn   = writesRd && (dec.rd != '0);
        dec.rs1Val = useRs1 ? fwdRs1 : '0;
        dec.rs2Val = useRs2 ? fwdRs2 : '0;
    end

    // A load in EX cannot forward yet; hold IF one cycle so the value arrives via MEM.
    assign loadUse = if_valid && ex_is_load && ex_wr_en && (ex_wr_addr != '0) &&
                     ((useRs1 && rs1 == ex_wr_addr) || (useRs2 && rs2 == ex_wr_addr));

    assign id_ready = flush || (ex_ready && !loadUse);

    always_comb begin
        if (flush)                      idex_d = '0;
        else if (!ex_ready)             idex_d = idex_q;
        else if (loadUse || !if_valid)  idex_d = '0;
        else                            idex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign id_valid     = idex_q.valid;
    assign id_pc        = idex_q.pc;
    assign id_rs1_val   = idex_q.rs1Val;
    assign id_rs2_val   = idex_q.rs2Val;
    assign id_imm       = idex_q.imm;
    assign id_use_imm   = idex_q.useImm;
    assign id_rd        = idex_q.rd;
    assign id_wr_en     = idex_q.wrEn;
    assign id_alu_op    = idex_q.aluOp;
    assign id_is_load   = idex_q.isLoad;
    assign id_is_store  = idex_q.isStore;
    assign id_is_branch = idex_q.isBranch;
    assign id_is_jump   = idex_q.isJump;
    assign id_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all compared
// against a behavioural model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        ex_wr_en;
    logic        ex_is_load;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic [3:0]  id_alu_op;
    logic        id_is_load;
    logic        id_is_store;
    logic        id_is_branch;
    logic        id_is_jump;
    logic        id_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_alu_op(id_alu_op), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        useImm;
        logic [4:0]  rd;
        logic        wrEn;
        logic [3:0]  alu;
        logic        ld;
        logic        st;
        logic        br;
        logic        jmp;
        logic        ill;
    } exp_t;

    exp_t expQ = '0;

    function automatic string kindOf(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:   return "OP";
            7'h13:   return "OPIMM";
            7'h03:   return "LOAD";
            7'h23:   return "STORE";
            7'h63:   return "BRANCH";
            7'h37:   return "LUI";
            7'h17:   return "AUIPC";
            7'h6F:   return "JAL";
            7'h67:   return "JALR";
            default: return "ILL";
        endcase
    endfunction

    function automatic logic usesRs1(input string k);
        return !(k == "LUI" || k == "AUIPC" || k == "JAL" || k == "ILL");
    endfunction

    function automatic logic usesRs2(input string k);
        return (k == "OP" || k == "STORE" || k == "BRANCH");
    endfunction

    // Immediates built as signed integers from the ISA field layout.
    function automatic logic [31:0] immOf(input logic [31:0] inst);
        string k = kindOf(inst);
        int    v = 0;
        if (k == "OPIMM" || k == "LOAD" || k == "JALR") v = $signed(inst[31:20]);
        else if (k == "STORE")  v = $signed({inst[31:25], inst[11:7]});
        else if (k == "BRANCH") v = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2;
        else if (k == "LUI" || k == "AUIPC") v = {inst[31:12], 12'h000};
        else if (k == "JAL")    v = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2;
        return 32'(v);
    endfunction

    function automatic logic [3:0] aluOf(input logic [31:0] inst);
        string      k = kindOf(inst);
        logic [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (k == "OP" || k == "OPIMM") begin
            if (inst[14:12] == 3'd0 && k == "OP" && inst[30]) return 4'd1;
            if (inst[14:12] == 3'd5 && inst[30]) return 4'd7;
            return base[inst[14:12]];
        end
        if (k == "LUI")    return 4'd10;
        if (k == "BRANCH") return 4'd1;
        return 4'd0;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (ex_wr_en && ex_wr_addr == a) return ex_wr_data;
        if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
        return rf;
    endfunction

    function automatic logic stallNow();
        string k = kindOf(if_inst);
        return if_valid && ex_is_load && ex_wr_en && ex_wr_addr != 5'd0 &&
               ((usesRs1(k) && if_inst[19:15] == ex_wr_addr) || (usesRs2(k) && if_inst[24:20] == ex_wr_addr));
    endfunction

    function automatic exp_t decoded();
        exp_t  e = '0;
        string k = kindOf(if_inst);
        e.valid  = 1'b1;
        e.pc     = if_pc;
        e.rd     = if_inst[11:7];
        e.wrEn   = !(k == "STORE" || k == "BRANCH" || k == "ILL") && if_inst[11:7] != 5'd0;
        e.useImm = !(k == "OP" || k == "BRANCH" || k == "ILL");
        e.imm    = immOf(if_inst);
        e.alu    = aluOf(if_inst);
        e.rs1    = usesRs1(k) ? operand(if_inst[19:15], rf_rdata1) : 32'd0;
        e.rs2    = usesRs2(k) ? operand(if_inst[24:20], rf_rdata2) : 32'd0;
        e.ld     = (k == "LOAD");
        e.st     = (k == "STORE");
        e.br     = (k == "BRANCH");
        e.jmp    = (k == "JAL" || k == "JALR");
        e.ill    = (k == "ILL");
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("id_valid",     32'(id_valid),     32'(expQ.valid));
        chk("id_pc",        id_pc,             expQ.pc);
        chk("id_rs1_val",   id_rs1_val,        expQ.rs1);
        chk("id_rs2_val",   id_rs2_val,        expQ.rs2);
        chk("id_imm",       id_imm,            expQ.imm);
        chk("id_use_imm",   32'(id_use_imm),   32'(expQ.useImm));
        chk("id_rd",        32'(id_rd),        32'(expQ.rd));
        chk("id_wr_en",     32'(id_wr_en),     32'(expQ.wrEn));
        chk("id_alu_op",    32'(id_alu_op),    32'(expQ.alu));
        chk("id_is_load",   32'(id_is_load),   32'(expQ.ld));
        chk("id_is_store",  32'(id_is_store),  32'(expQ.st));
        chk("id_is_branch", 32'(id_is_branch), 32'(expQ.br));
        chk("id_is_jump",   32'(id_is_jump),   32'(expQ.jmp));
        chk("id_illegal",   32'(id_illegal),   32'(expQ.ill));
    endtask

    // Inputs are already driven; check combinational outputs, clock once, check ID/EX.
    task automatic applyStimulus();
        exp_t nxt;
        logic st;
        #1;
        st = stallNow();
        chk("rf_raddr1", 32'(rf_raddr1), 32'(if_inst[19:15]));
        chk("rf_raddr2", 32'(rf_raddr2), 32'(if_inst[24:20]));
        chk("id_ready",  32'(id_ready),  32'(flush || (ex_ready && !st)));
        if (rst)                   nxt = '0;
        else if (flush)            nxt = '0;
        else if (!ex_ready)        nxt = expQ;
        else if (st || !if_valid)  nxt = '0;
        else                       nxt = decoded();
        @(posedge clk);
        #1;
        expQ = nxt;
        checkOutput();
    endtask

    task automatic clearSide();
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 32'hDEAD_0001;
        mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 32'hDEAD_0002;
        flush = 0; ex_ready = 1;
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

        clearSide();
        rst = 1; if_valid = 1; if_pc = 32'h0; if_inst = 32'h0050_0093;
        rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
        applyStimulus();
        applyStimulus();

        rst = 0;
        applyStimulus();
        chk("rst_rel_valid", 32'(id_valid),  32'd1);
        chk("rst_rel_rd",    32'(id_rd),     32'd1);
        chk("rst_rel_imm",   id_imm,         32'd5);
        chk("rst_rel_alu",   32'(id_alu_op), 32'd0);

        if_pc = 32'h4; if_inst = 32'h0020_81B3; rf_rdata1 = 32'd7; rf_rdata2 = 32'd9;
        applyStimulus();
        chk("add_rs1", id_rs1_val, 32'd7);
        chk("add_rs2", id_rs2_val, 32'd9);

        ex_wr_en = 1; ex_wr_addr = 5'd1; ex_wr_data = 32'hAA;
        mem_wr_en = 1; mem_wr_addr = 5'd1; mem_wr_data = 32'hBB;
        if_pc = 32'h8;
        applyStimulus();
        chk("fwd_ex_prio", id_rs1_val, 32'hAA);

        ex_wr_addr = 5'd0; if_inst = 32'h0020_01B3; if_pc = 32'hC;
        applyStimulus();
        chk("fwd_x0", id_rs1_val, 32'd0);

        clearSide();
        ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 5'd1; ex_wr_data = 32'h5555;
        if_inst = 32'h0020_81B3; if_pc = 32'h10;
        applyStimulus();
        chk("loaduse_bubble", 32'(id_valid), 32'd0);

        clearSide();
        mem_wr_en = 1; mem_wr_addr = 5'd1; mem_wr_data = 32'h1234;
        applyStimulus();
        chk("loaduse_mem", id_rs1_val, 32'h1234);
        chk("loaduse_valid", 32'(id_valid), 32'd1);

        clearSide();
        ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 5'd2; flush = 1; if_pc = 32'h14;
        applyStimulus();
        chk("flush_valid", 32'(id_valid), 32'd0);

        clearSide();
        if_inst = 32'h0000_0FFF; if_pc = 32'h18;
        applyStimulus();
        chk("illegal_flag", 32'(id_illegal), 32'd1);
        chk("illegal_wr",   32'(id_wr_en),   32'd0);

        if_inst = 32'h0030_0113; if_pc = 32'h100;
        applyStimulus();
        if_inst = 32'h0020_81B3; if_pc = 32'h104; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            chk("hold_pc", id_pc, 32'h100);
        end
        ex_ready = 1;
        applyStimulus();
        chk("release_pc", id_pc, 32'h104);

        for (int n = 0; n < 400; n++) begin
            if_inst        = $urandom;
            if_inst[6:0]   = ops[$urandom_range(0, 9)];
            if_inst[19:15] = 5'($urandom_range(0, 3));
            if_inst[24:20] = 5'($urandom_range(0, 3));
            if_pc       = $urandom;
            if_valid    = ($urandom_range(0, 5) != 0);
            rf_rdata1   = $urandom;
            rf_rdata2   = $urandom;
            ex_wr_en    = $urandom_range(0, 1) != 0;
            ex_is_load  = $urandom_range(0, 2) == 0;
            ex_wr_addr  = 5'($urandom_range(0, 3));
            ex_wr_data  = $urandom;
            mem_wr_en   = $urandom_range(0, 1) != 0;
            mem_wr_addr = 5'($urandom_range(0, 3));
            mem_wr_data = $urandom;
            flush       = ($urandom_range(0, 9) == 0);
            ex_ready    = ($urandom_range(0, 4) != 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
